// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants, state enum and status helper for the calculator command sequencer
package calc_pkg;

  // Core status encodings (2'b11 is treated as an error)
  localparam logic [1:0] ST_ERR   = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;

  // Keypad operator codes
  localparam logic [3:0] CMD_ADD  = 4'hA;
  localparam logic [3:0] CMD_SUB  = 4'hB;
  localparam logic [3:0] CMD_MUL  = 4'hC;
  localparam logic [3:0] CMD_EQ   = 4'hE;
  localparam logic [3:0] CMD_BKSP = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_READY,
    ERROR
  } seq_state_t;

  // Both 00 and the undefined 11 count as a core fault
  function automatic logic status_is_err(input logic [1:0] status);
    return (status == ST_ERR) || (status == 2'b11);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - keypad code FIFO with push/pop/flush, full/empty flags and occupancy level
//
// Ports:
//   clock_i, reset_i       : clock, asynchronous active-high reset
//   flush_i                : empties the FIFO; wins over a same-cycle push/pop
//   push_i, data_i         : write data_i at the tail (ignored when full)
//   pop_i, data_o          : data_o is the head; pop_i advances it (ignored when empty)
//   full_o, empty_o        : occupancy flags
//   level_o                : number of stored entries, 0..DEPTH
module cmd_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset; stale entries are never visible once pointers clear
  always_ff @(posedge clock_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// rtl/calc_cmd_sequencer.sv - issues buffered keypad codes to the calculator core one per ready window
//
// Ports:
//   clock_i, reset_i  : clock, asynchronous active-high reset
//   key_valid_i       : keypad code present, accepted when key_ready_o=1
//   key_code_i        : keypad code (digits, operators, equals, backspace)
//   calc_status_i     : core status (00 err, 01 busy, 10 ready, 11 err)
//   clear_i           : synchronous clear of flags, FIFO and FSM
//   cmd_o             : registered command to the core (IDLE_CMD when nothing active)
//   key_ready_o       : FIFO not full and not in ERROR
//   fifo_level_o      : FIFO occupancy
//   busy_o            : a command is in flight (ISSUE or WAIT_READY)
//   err_o, timeout_o  : sticky core-error and acknowledge-timeout flags
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 8,
  parameter int         ACK_TIMEOUT = 16,
  parameter logic [3:0] IDLE_CMD    = 4'hD
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         key_valid_i,
  input  logic [3:0]                   key_code_i,
  input  logic [1:0]                   calc_status_i,
  input  logic                         clear_i,
  output logic [3:0]                   cmd_o,
  output logic                         key_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
  output logic                         busy_o,
  output logic                         err_o,
  output logic                         timeout_o
);

  localparam int CW = $clog2(ACK_TIMEOUT) + 1;

  seq_state_t       state_q;
  logic [3:0]       cmd_q;
  logic [CW-1:0]    cnt_q;
  logic             err_q;
  logic             timeout_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic [3:0]       fifo_head;
  logic             push;
  logic             pop;
  logic             flush;
  logic             go_err;

  // Status faults only matter while a command is in flight
  assign go_err = ((state_q == ISSUE) || (state_q == WAIT_READY)) && status_is_err(calc_status_i);
  assign pop    = (state_q == IDLE) && (calc_status_i == ST_READY) && !fifo_empty && !clear_i;
  assign push   = key_valid_i && key_ready_o;
  // Flushing on the entry edge too, so the FIFO reads empty as soon as ERROR is visible
  assign flush  = clear_i || (state_q == ERROR) || go_err;

  assign key_ready_o = !fifo_full && (state_q != ERROR);
  assign busy_o      = (state_q == ISSUE) || (state_q == WAIT_READY);
  assign cmd_o       = cmd_q;
  assign err_o       = err_q;
  assign timeout_o   = timeout_q;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (key_code_i),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cmd_q     <= IDLE_CMD;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else if (clear_i) begin
      state_q   <= IDLE;
      cmd_q     <= IDLE_CMD;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            cmd_q   <= fifo_head;
            cnt_q   <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (go_err) begin
            err_q   <= 1'b1;
            cmd_q   <= IDLE_CMD;
            state_q <= ERROR;
          end else if (calc_status_i == ST_BUSY) begin
            // Drop the code on the edge the core acknowledges it
            cmd_q   <= IDLE_CMD;
            state_q <= WAIT_READY;
          end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            cmd_q     <= IDLE_CMD;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_READY: begin
          if (go_err) begin
            err_q   <= 1'b1;
            state_q <= ERROR;
          end else if (calc_status_i == ST_READY) begin
            state_q <= IDLE;
          end
        end
        ERROR: begin
          err_q <= 1'b1;
          cmd_q <= IDLE_CMD;
        end
        default: begin
          state_q <= IDLE;
          cmd_q   <= IDLE_CMD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// tb/tb_calc_cmd_sequencer.sv - self-checking bench for calc_cmd_sequencer
module tb_calc_cmd_sequencer;

  localparam int         DEPTH    = 8;
  localparam int         ACK      = 16;
  localparam logic [3:0] IDLE_CMD = 4'hD;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [1:0] calc_status = 2'b01;
  logic       clear = 1'b0;
  logic [3:0] cmd;
  logic       key_ready;
  logic [3:0] fifo_level;
  logic       busy;
  logic       err;
  logic       timeout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  calc_cmd_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .ACK_TIMEOUT (ACK),
    .IDLE_CMD    (IDLE_CMD)
  ) dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .key_valid_i   (key_valid),
    .key_code_i    (key_code),
    .calc_status_i (calc_status),
    .clear_i       (clear),
    .cmd_o         (cmd),
    .key_ready_o   (key_ready),
    .fifo_level_o  (fifo_level),
    .busy_o        (busy),
    .err_o         (err),
    .timeout_o     (timeout)
  );

  typedef struct {
    bit         kv;
    logic [3:0] kc;
    logic [1:0] st;
    bit         clr;
    logic [3:0] e_cmd;
    int         e_lvl;
    bit         e_busy;
    bit         e_kr;
    bit         e_err;
    bit         e_to;
  } vec_t;

  vec_t tbl [14];

  // Transaction-level reference: a queue of pending codes plus "in flight" bookkeeping
  logic [3:0] mq [$];
  logic [3:0] m_cmd;
  bit         m_issued;
  bit         m_waiting;
  bit         m_locked;
  bit         m_err;
  bit         m_to;
  int         m_age;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string name, input logic [3:0] e_cmd, input int e_lvl,
                           input bit e_busy, input bit e_kr, input bit e_err, input bit e_to);
    vectors++;
    if (cmd !== e_cmd || fifo_level !== 4'(e_lvl) || busy !== e_busy ||
        key_ready !== e_kr || err !== e_err || timeout !== e_to) begin
      miscompares++;
      $display("FAIL %s: got cmd=%h lvl=%0d busy=%b rdy=%b err=%b to=%b, want cmd=%h lvl=%0d busy=%b rdy=%b err=%b to=%b",
               name, cmd, fifo_level, busy, key_ready, err, timeout,
               e_cmd, e_lvl, e_busy, e_kr, e_err, e_to);
    end
  endtask

  task automatic check1(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cmd     = IDLE_CMD;
    m_issued  = 1'b0;
    m_waiting = 1'b0;
    m_locked  = 1'b0;
    m_err     = 1'b0;
    m_to      = 1'b0;
    m_age     = 0;
  endtask

  task automatic model_step(input bit kv, input logic [3:0] kc, input logic [1:0] st, input bit clr);
    bit pushing;
    bit bad;
    pushing = kv && !m_locked && (mq.size() < DEPTH);
    bad     = (st == 2'b00) || (st == 2'b11);
    if (clr) begin
      model_reset();
      return;
    end
    if (m_locked) begin
      mq.delete();
      return;
    end
    if ((m_issued || m_waiting) && bad) begin
      m_locked  = 1'b1;
      m_err     = 1'b1;
      m_issued  = 1'b0;
      m_waiting = 1'b0;
      m_cmd     = IDLE_CMD;
      mq.delete();
      return;
    end
    if (m_issued) begin
      if (st == 2'b01) begin
        m_issued  = 1'b0;
        m_waiting = 1'b1;
        m_cmd     = IDLE_CMD;
      end else begin
        m_age++;
        if (m_age == ACK) begin
          m_to     = 1'b1;
          m_issued = 1'b0;
          m_cmd    = IDLE_CMD;
        end
      end
    end else if (m_waiting) begin
      if (st == 2'b10) m_waiting = 1'b0;
    end else if (st == 2'b10 && mq.size() > 0) begin
      m_cmd    = mq.pop_front();
      m_issued = 1'b1;
      m_age    = 0;
    end
    if (pushing) mq.push_back(kc);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    key_valid   = 1'b0;
    key_code    = 4'h0;
    clear       = 1'b0;
    calc_status = 2'b01;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int n;
    int mode;
    int r;

    //          kv    kc     st     clr   cmd    lvl busy  rdy   err   to
    tbl[0]  = '{1'b1, 4'h3, 2'b01, 1'b0, 4'hD, 1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'hA, 2'b10, 1'b0, 4'h3, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'h0, 2'b10, 1'b0, 4'h3, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'h0, 2'b01, 1'b0, 4'hD, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'h0, 2'b01, 1'b0, 4'hD, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 2'b10, 1'b0, 4'hD, 1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'h0, 2'b10, 1'b0, 4'hA, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'h0, 2'b00, 1'b0, 4'hD, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 4'h5, 2'b10, 1'b0, 4'hD, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 4'h7, 2'b10, 1'b1, 4'hD, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'h7, 2'b01, 1'b0, 4'hD, 1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'hC, 2'b10, 1'b0, 4'h7, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'h0, 2'b01, 1'b0, 4'hD, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'h0, 2'b11, 1'b0, 4'hD, 0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset values and directed table
    do_reset();
    check_all("reset", IDLE_CMD, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      key_valid   = tbl[i].kv;
      key_code    = tbl[i].kc;
      calc_status = tbl[i].st;
      clear       = tbl[i].clr;
      tick();
      check_all($sformatf("tbl%0d", i), tbl[i].e_cmd, tbl[i].e_lvl, tbl[i].e_busy,
                tbl[i].e_kr, tbl[i].e_err, tbl[i].e_to);
    end
    key_valid = 1'b0;
    clear     = 1'b0;

    // Fill while the core is stuck busy: 9th code is dropped
    do_reset();
    calc_status = 2'b01;
    for (int i = 0; i < 9; i++) begin
      key_valid = 1'b1;
      key_code  = 4'(i);
      tick();
      check_all($sformatf("fill%0d", i), IDLE_CMD, (i + 1 > DEPTH) ? DEPTH : i + 1,
                1'b0, (i + 1 < DEPTH), 1'b0, 1'b0);
    end
    key_valid = 1'b0;

    // Acknowledge timeout, then the next queued code issues
    do_reset();
    calc_status = 2'b10;
    key_valid   = 1'b1;
    key_code    = 4'h4;
    tick();
    key_code = 4'h6;
    tick();
    key_valid = 1'b0;
    check_all("to_issue", 4'h4, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (timeout === 1'b1) break;
    end
    check1("to_cycles", n, ACK);
    check_all("to_fire", IDLE_CMD, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    check_all("to_next", 4'h6, 0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Long multiply: busy for 40 cycles without timing out
    do_reset();
    calc_status = 2'b10;
    key_valid   = 1'b1;
    key_code    = 4'hC;
    tick();
    key_valid = 1'b0;
    tick();
    check_all("mul_issue", 4'hC, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    calc_status = 2'b01;
    for (int i = 0; i < 40; i++) begin
      tick();
      check_all($sformatf("mul_busy%0d", i), IDLE_CMD, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    calc_status = 2'b10;
    tick();
    check_all("mul_done", IDLE_CMD, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in ISSUE with 5 codes queued
    do_reset();
    calc_status = 2'b01;
    for (int i = 0; i < 6; i++) begin
      key_valid = 1'b1;
      key_code  = 4'(i + 1);
      tick();
    end
    key_valid   = 1'b0;
    calc_status = 2'b10;
    tick();
    check_all("rst_pre", 4'h1, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_all("rst_async", IDLE_CMD, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic against the reference model
    do_reset();
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) mode = $urandom_range(0, 2);
      r = $urandom_range(0, 99);
      case (mode)
        0:       calc_status = (r < 45) ? 2'b10 : (r < 94) ? 2'b01 : (r < 97) ? 2'b00 : 2'b11;
        1:       calc_status = (r < 96) ? 2'b10 : 2'b01;
        default: calc_status = (r < 30) ? 2'b10 : (r < 99) ? 2'b01 : 2'b00;
      endcase
      key_valid = ($urandom_range(0, 1) == 1);
      key_code  = 4'($urandom_range(0, 15));
      clear     = ($urandom_range(0, 49) == 0);
      model_step(key_valid, key_code, calc_status, clear);
      tick();
      check_all("rand", m_cmd, mq.size(), m_issued || m_waiting,
                !m_locked && (mq.size() < DEPTH), m_err, m_to);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
